// File: rtl/lcdbuf_pkg.sv
// Shared types and helpers for the SC1602 character buffer.
// Provides depth, fill character, FSM states and the LCD address map.
package lcdbuf_pkg;

    localparam int         LCDBUF_DEPTH = 32;
    localparam int         LCDBUF_AW    = 5;
    localparam logic [7:0] LCDBUF_SPACE = 8'h20;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } lcdbuf_state_e;

    // Returns {valid, idx}: idx = {line, column}; valid clear for
    // addresses outside 8'h00-8'h0F and 8'h40-8'h4F.
    function automatic logic [5:0] lcdbuf_map(input logic [7:0] a);
        logic ok;
        ok = !a[7] && (a[5:4] == 2'b00);
        return {ok, a[6], a[3:0]};
    endfunction

endpackage

// File: rtl/lcdbuf_ram.sv
// 32x8 single-port synchronous RAM with registered read.
// Ports: clk, we/re strobes, addr, wdata, rdata (updated only on re).
module lcdbuf_ram
    import lcdbuf_pkg::*;
(
    input  logic                 clk,
    input  logic                 we,
    input  logic                 re,
    input  logic [LCDBUF_AW-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] mem_q [LCDBUF_DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lcd_char_buf_arb.sv
// Character buffer for the LCD path: driver reads win every edge, a
// clear engine (macro LCDBUF_CLEAR_EN) fills spaces, then two clients
// share the remaining write slots round-robin.
// Ports: clk, resetn, lcd_addr/lcd_rd/lcd_data (driver read port),
// cN_req/cN_addr/cN_wdata/cN_gnt (client writes), clr_req/clr_busy.
module lcd_char_buf_arb
    import lcdbuf_pkg::*;
#(
    parameter logic [7:0] SPACE_CHAR = LCDBUF_SPACE
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] lcd_addr,
    input  logic       lcd_rd,
    output logic [7:0] lcd_data,
    input  logic       c0_req,
    input  logic [4:0] c0_addr,
    input  logic [7:0] c0_wdata,
    output logic       c0_gnt,
    input  logic       c1_req,
    input  logic [4:0] c1_addr,
    input  logic [7:0] c1_wdata,
    output logic       c1_gnt,
    input  logic       clr_req,
    output logic       clr_busy
);

    logic [5:0] map;
    logic       clr_act;
    logic [4:0] clr_idx;
    logic       cli_slot;
    logic       gnt0_d;
    logic       gnt1_d;
    logic       gnt0_q;
    logic       gnt1_q;
    logic       last_q;
    logic       sel_q;
    logic       ram_we;
    logic       ram_re;
    logic [4:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    assign map    = lcdbuf_map(lcd_addr);
    assign ram_re = lcd_rd && map[5];

`ifdef LCDBUF_CLEAR_EN
    lcdbuf_state_e state_q;
    logic [4:0]    clr_idx_q;

    assign clr_act = (state_q == ST_CLEAR);
    assign clr_idx = clr_idx_q;
`else
    logic unused_clr;

    assign unused_clr = clr_req;
    assign clr_act    = 1'b0;
    assign clr_idx    = 5'd0;
`endif

    // Clients only see edges that neither a read nor the clear claims.
    assign cli_slot = !lcd_rd && !clr_act;
    assign gnt0_d   = cli_slot && c0_req && (!c1_req || last_q);
    assign gnt1_d   = cli_slot && c1_req && (!c0_req || !last_q);

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = map[4:0];
        ram_wdata = c0_wdata;
        if (lcd_rd) begin
            ram_we = 1'b0;
        end else if (clr_act) begin
            ram_we    = 1'b1;
            ram_addr  = clr_idx;
            ram_wdata = SPACE_CHAR;
        end else if (gnt0_d) begin
            ram_we    = 1'b1;
            ram_addr  = c0_addr;
            ram_wdata = c0_wdata;
        end else if (gnt1_d) begin
            ram_we    = 1'b1;
            ram_addr  = c1_addr;
            ram_wdata = c1_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            last_q <= 1'b1;
            sel_q  <= 1'b0;
`ifdef LCDBUF_CLEAR_EN
            state_q   <= ST_CLEAR;
            clr_idx_q <= 5'd0;
`endif
        end else begin
            gnt0_q <= gnt0_d;
            gnt1_q <= gnt1_d;
            if (gnt0_d) begin
                last_q <= 1'b0;
            end else if (gnt1_d) begin
                last_q <= 1'b1;
            end
            // sel_q picks RAM data for mapped reads, SPACE otherwise.
            if (lcd_rd) begin
                sel_q <= map[5];
            end
`ifdef LCDBUF_CLEAR_EN
            unique case (state_q)
                ST_CLEAR: begin
                    if (!lcd_rd) begin
                        if (clr_idx_q == 5'd31) begin
                            state_q <= ST_RUN;
                        end
                        clr_idx_q <= clr_idx_q + 5'd1;
                    end
                end
                ST_RUN: begin
                    if (clr_req) begin
                        state_q   <= ST_CLEAR;
                        clr_idx_q <= 5'd0;
                    end
                end
            endcase
`endif
        end
    end

    lcdbuf_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign lcd_data = sel_q ? ram_rdata : SPACE_CHAR;
    assign c0_gnt   = gnt0_q;
    assign c1_gnt   = gnt1_q;
    assign clr_busy = clr_act;

endmodule

// File: tb/tb_lcd_char_buf_arb.sv
// Self-checking bench for lcd_char_buf_arb: directed cases plus
// randomized traffic against a cycle-level behavioural buffer model.
module tb_lcd_char_buf_arb;

    localparam logic [7:0] SP = 8'h20;
`ifdef LCDBUF_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] lcd_addr;
    logic       lcd_rd;
    logic [7:0] lcd_data;
    logic       c0_req, c1_req;
    logic [4:0] c0_addr, c1_addr;
    logic [7:0] c0_wdata, c1_wdata;
    logic       c0_gnt, c1_gnt;
    logic       clr_req;
    logic       clr_busy;

    always #5 clk = ~clk;

    lcd_char_buf_arb dut (
        .clk      (clk),
        .resetn   (resetn),
        .lcd_addr (lcd_addr),
        .lcd_rd   (lcd_rd),
        .lcd_data (lcd_data),
        .c0_req   (c0_req),
        .c0_addr  (c0_addr),
        .c0_wdata (c0_wdata),
        .c0_gnt   (c0_gnt),
        .c1_req   (c1_req),
        .c1_addr  (c1_addr),
        .c1_wdata (c1_wdata),
        .c1_gnt   (c1_gnt),
        .clr_req  (clr_req),
        .clr_busy (clr_busy)
    );

    // Behavioural model: buffer contents plus what the outputs must be.
    logic [7:0] m_mem [32];
    bit         m_known [32];
    bit         m_clr;
    int         m_cidx;
    int         m_last;
    logic [7:0] m_data;
    bit         m_data_ok;
    bit         m_g0, m_g1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk8(input string nm, input logic [7:0] act,
                        input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_clr     = CLR_EN;
        m_cidx    = 0;
        m_last    = 1;
        m_data    = SP;
        m_data_ok = 1'b1;
        m_g0      = 1'b0;
        m_g1      = 1'b0;
    endtask

    // One edge of the buffer, from the inputs present at that edge.
    task automatic model_step();
        bit was;
        int w;
        int idx;
        was  = m_clr;
        m_g0 = 1'b0;
        m_g1 = 1'b0;
        if (lcd_rd) begin
            if (!lcd_addr[7] && lcd_addr[5:4] == 2'b00) begin
                idx       = lcd_addr[6] * 16 + int'(lcd_addr[3:0]);
                m_data    = m_mem[idx];
                m_data_ok = m_known[idx];
            end else begin
                m_data    = SP;
                m_data_ok = 1'b1;
            end
        end else if (m_clr) begin
            m_mem[m_cidx]   = SP;
            m_known[m_cidx] = 1'b1;
            if (m_cidx == 31) m_clr = 1'b0;
            else m_cidx++;
        end else if (c0_req || c1_req) begin
            if (c0_req && c1_req) w = 1 - m_last;
            else w = c0_req ? 0 : 1;
            if (w == 0) begin
                m_mem[c0_addr]   = c0_wdata;
                m_known[c0_addr] = 1'b1;
                m_g0             = 1'b1;
            end else begin
                m_mem[c1_addr]   = c1_wdata;
                m_known[c1_addr] = 1'b1;
                m_g1             = 1'b1;
            end
            m_last = w;
        end
        if (CLR_EN && !was && clr_req) begin
            m_clr  = 1'b1;
            m_cidx = 0;
        end
    endtask

    // The single compare point: every edge, 1 time unit after it.
    task automatic cycle();
        @(posedge clk);
        if (resetn) model_step();
        #1;
        chk1("c0_gnt", c0_gnt, m_g0);
        chk1("c1_gnt", c1_gnt, m_g1);
        chk1("clr_busy", clr_busy, m_clr);
        if (m_data_ok) chk8("lcd_data", lcd_data, m_data);
    endtask

    task automatic idle_inputs();
        lcd_rd   = 1'b0;
        lcd_addr = 8'h00;
        c0_req   = 1'b0;
        c1_req   = 1'b0;
        clr_req  = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        model_reset();
        cycle();
        cycle();
        resetn = 1'b1;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a,
                          input logic [7:0] exp);
        lcd_rd   = 1'b1;
        lcd_addr = a;
        cycle();
        lcd_rd = 1'b0;
        chk8(nm, lcd_data, exp);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) m_known[i] = 1'b0;
        c0_addr  = 5'd0;
        c1_addr  = 5'd0;
        c0_wdata = 8'h00;
        c1_wdata = 8'h00;
        do_reset();
        chk8("rst_lcd_data", lcd_data, 8'h20);
        chk1("rst_c0_gnt", c0_gnt, 1'b0);
        chk1("rst_c1_gnt", c1_gnt, 1'b0);

`ifdef LCDBUF_CLEAR_EN
        n = 0;
        for (int i = 0; i < 40 && clr_busy; i++) begin
            n++;
            cycle();
        end
        chkn("boot_clear_len", n, 32);
        rd_chk("boot_rd_00", 8'h00, 8'h20);
        rd_chk("boot_rd_0f", 8'h0F, 8'h20);
        rd_chk("boot_rd_40", 8'h40, 8'h20);
        rd_chk("boot_rd_4f", 8'h4F, 8'h20);
`endif

        // Tie with last=1: c0 first, c1 the edge after.
        c0_req = 1'b1; c0_addr = 5'd5;  c0_wdata = 8'h41;
        c1_req = 1'b1; c1_addr = 5'd21; c1_wdata = 8'h42;
        cycle();
        chk1("tie_c0_first", c0_gnt, 1'b1);
        chk1("tie_c1_wait", c1_gnt, 1'b0);
        c0_req = 1'b0;
        cycle();
        chk1("tie_c1_next", c1_gnt, 1'b1);
        c1_req = 1'b0;
        rd_chk("tie_rd_05", 8'h05, 8'h41);
        rd_chk("tie_rd_45", 8'h45, 8'h42);

        // Reads hold off a lone client for three edges.
        c0_req = 1'b1; c0_addr = 5'd7; c0_wdata = 8'h55;
        lcd_rd = 1'b1; lcd_addr = 8'h05;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk1("rdblk_no_gnt", c0_gnt, 1'b0);
            chk8("rdblk_data", lcd_data, 8'h41);
        end
        lcd_rd = 1'b0;
        cycle();
        chk1("rdblk_gnt_4th", c0_gnt, 1'b1);
        c0_req = 1'b0;
        rd_chk("rdblk_rd_07", 8'h07, 8'h55);

        // Back-to-back writes from a single client.
        c0_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c0_addr  = 5'(i);
            c0_wdata = 8'h30 + 8'(i);
            cycle();
            chk1("b2b_gnt", c0_gnt, 1'b1);
        end
        c0_req = 1'b0;
        rd_chk("b2b_rd_00", 8'h00, 8'h30);
        rd_chk("b2b_rd_01", 8'h01, 8'h31);
        rd_chk("b2b_rd_02", 8'h02, 8'h32);
        rd_chk("b2b_rd_03", 8'h03, 8'h33);

        // Unmapped reads give SPACE and leave the RAM alone.
        rd_chk("unmap_20", 8'h20, 8'h20);
        rd_chk("unmap_80", 8'h80, 8'h20);
        rd_chk("unmap_keep_05", 8'h05, 8'h41);

`ifdef LCDBUF_CLEAR_EN
        // Clear on request; a second request mid-clear is ignored.
        clr_req = 1'b1;
        cycle();
        n = 0;
        for (int i = 0; i < 100 && clr_busy; i++) begin
            clr_req = (i == 10);
            n++;
            cycle();
        end
        clr_req = 1'b0;
        chkn("req_clear_len", n, 32);
        rd_chk("clr_rd_00", 8'h00, 8'h20);
        rd_chk("clr_rd_05", 8'h05, 8'h20);
        rd_chk("clr_rd_4f", 8'h4F, 8'h20);
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            lcd_rd = ($urandom % 3 == 0);
            if ($urandom % 8 == 0) lcd_addr = 8'($urandom);
            else lcd_addr = {1'b0, 1'($urandom), 2'b00, 4'($urandom)};
            if (!c0_req || m_g0) begin
                c0_req   = ($urandom % 3 != 0);
                c0_addr  = 5'($urandom);
                c0_wdata = 8'($urandom);
            end
            if (!c1_req || m_g1) begin
                c1_req   = ($urandom % 3 != 0);
                c1_addr  = 5'($urandom);
                c1_wdata = 8'($urandom);
            end
            clr_req = CLR_EN && ($urandom % 150 == 0);
            if ($urandom % 900 == 0) do_reset();
            cycle();
        end

        idle_inputs();
        cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
